mem_req_port: RTL and testbench

- Per-core requester-side port for the shared 8-way DRAM/IRAM memory controllers.
- Turns a core's single load/store request into the controller's level-held rden/wren + Address + Din protocol.
- Waits for the controller's acq grant, captures read data from Dq, and returns a one-cycle response to the core.
- One instance sits between each core and its slot on a MemController8/IMemController8; it is the initiator end of that arbitration interface.

---
 rtl/mem_req_port_if.sv | 40 ++++
 rtl/mem_req_port.sv | 176 +++++++++++++++++
 tb/tb_mem_req_port.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_port_if.sv
// ----------------------------------------------------------------------------
// mem_req_port_if
// Requester-to-controller bus for one slot of a shared 8-way memory
// controller (MemController8 / IMemController8).
//
// Signals:
//   Mem_Ctrl [3:0]  bit0 = rden, bit1 = wren, bits[3:2] = 0 (requester drives)
//   Address  [AW]   access address                           (requester drives)
//   Din      [DW]   write data                               (requester drives)
//   Dq       [DW]   registered RAM read data                 (controller drives)
//   acq             grant for this slot                      (controller drives)
//
// Modports: master = requester port, slave = controller slot.
// ----------------------------------------------------------------------------
interface mem_req_port_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [3:0]    Mem_Ctrl;
    logic [AW-1:0] Address;
    logic [DW-1:0] Din;
    logic [DW-1:0] Dq;
    logic          acq;

    modport master (
        output Mem_Ctrl,
        output Address,
        output Din,
        input  Dq,
        input  acq
    );

    modport slave (
        input  Mem_Ctrl,
        input  Address,
        input  Din,
        output Dq,
        output acq
    );
endinterface

// File: rtl/mem_req_port.sv
// ----------------------------------------------------------------------------
// mem_req_port
// Per-core requester port for a shared memory controller slot. Converts one
// load/store request from the core into the level-held rden/wren + Address +
// Din protocol, waits for acq, captures Dq one cycle after the read grant and
// returns a single-cycle response to the core.
//
// Optional feature: define MEMPORT_TIMEOUT_EN to abort a request that has not
// been granted within TIMEOUT_CYC REQ cycles (response with rsp_err = 1).
//
// Ports:
//   CLK, rst    clock, synchronous active-high reset
//   req_*       core request (valid/we/addr/wdata), req_ready = idle
//   rsp_*       response pulse, read data (held), error qualifier
//   bus         controller-side bus (mem_req_port_if.master)
//   busy        high while a request is in flight (feeds clkdiv busy OR)
// ----------------------------------------------------------------------------
module mem_req_port #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    mem_req_port_if.master bus,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ctrl_q, ctrl_d;      // {wren, rden}
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rsp_valid_d;

`ifdef MEMPORT_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    // Count value seen in the last permitted REQ cycle without a grant.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
`ifdef MEMPORT_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    din_d   = req_wdata;
                    ctrl_d  = {req_we, ~req_we};
                    state_d = REQ;
`ifdef MEMPORT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            REQ: begin
                // A grant always wins over a simultaneous timeout expiry.
                if (bus.acq) begin
                    ctrl_d = 2'b00;
                    if (ctrl_q[1]) begin
                        // Write committed on this acq cycle.
                        rsp_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        // Registered RAM: Dq is valid in the following cycle.
                        state_d = RDATA;
                    end
                end
`ifdef MEMPORT_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    ctrl_d      = 2'b00;
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                    if (ctrl_q[0]) begin
                        rdata_d = '1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            RDATA: begin
                rdata_d     = bus.Dq;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                ctrl_d  = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled at the same edge.
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= 2'b00;
            addr_q    <= '0;
            din_q     <= '0;
            rdata_q   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rdata_q   <= rdata_d;
            rsp_valid <= rsp_valid_d;
        end
    end

`ifdef MEMPORT_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rsp_rdata    = rdata_q;
    assign bus.Mem_Ctrl = {2'b00, ctrl_q};
    assign bus.Address  = addr_q;
    assign bus.Din      = din_q;

endmodule

// File: tb/tb_mem_req_port.sv
// ----------------------------------------------------------------------------
// tb_mem_req_port
// Directed self-checking bench for mem_req_port. The controller side (acq, Dq)
// is driven directly by the stimulus; inputs change and outputs are sampled
// on the falling edge of CLK.
// ----------------------------------------------------------------------------
module tb_mem_req_port;

    localparam int AW = 8;
    localparam int DW = 8;
`ifdef MEMPORT_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          CLK = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_req_port_if #(.AW(AW), .DW(DW)) bus ();

    mem_req_port #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus.master),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: across the rising edge, back to the sampling (falling) edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Present a request for one edge; returns at the negedge of cycle T+1.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        bus.acq   = 1'b0;
        bus.Dq    = '0;
        @(negedge CLK);
        tick();

        // ---------------- reset state ----------------
        check("rst_ready",  req_ready,    1);
        check("rst_busy",   busy,         0);
        check("rst_ctrl",   bus.Mem_Ctrl, 4'b0000);
        check("rst_addr",   bus.Address,  8'h00);
        check("rst_din",    bus.Din,      8'h00);
        check("rst_rvalid", rsp_valid,    0);
        check("rst_rdata",  rsp_rdata,    8'h00);
        check("rst_err",    rsp_err,      0);
        rst = 1'b0;
        tick();

        // ---------------- read 0x12, immediate grant ----------------
        bus.acq = 1'b1;                 // also high in IDLE: must be ignored there
        issue(1'b0, 8'h12, 8'hEE);      // now in cycle T+1
        check("rd1_ctrl_t1",  bus.Mem_Ctrl, 4'b0001);
        check("rd1_addr_t1",  bus.Address,  8'h12);
        check("rd1_busy_t1",  busy,         1);
        check("rd1_ready_t1", req_ready,    0);
        tick();                          // T+2: RDATA
        bus.acq = 1'b0;
        bus.Dq  = 8'hA5;
        check("rd1_ctrl_t2",   bus.Mem_Ctrl, 4'b0000);
        check("rd1_busy_t2",   busy,         1);
        check("rd1_rvalid_t2", rsp_valid,    0);
        tick();                          // T+3: response
        bus.Dq  = 8'h00;
        check("rd1_rvalid_t3", rsp_valid, 1);
        check("rd1_rdata_t3",  rsp_rdata, 8'hA5);
        check("rd1_err_t3",    rsp_err,   0);
        check("rd1_busy_t3",   busy,      0);
        tick();
        check("rd1_rvalid_t4", rsp_valid, 0);
        check("rd1_rdata_t4",  rsp_rdata, 8'hA5);

        // ---------------- write 0x40/0x3C, grant after 5 waits ----------------
        issue(1'b1, 8'h40, 8'h3C);
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("wr_ctrl_c%0d", i), bus.Mem_Ctrl, 4'b0010);
            check($sformatf("wr_addr_c%0d", i), bus.Address,  8'h40);
            check($sformatf("wr_din_c%0d",  i), bus.Din,      8'h3C);
            check($sformatf("wr_rv_c%0d",   i), rsp_valid,    0);
            bus.acq = (i == 6);
            tick();
        end
        bus.acq = 1'b0;                  // now cycle T+7
        check("wr_rvalid_t7", rsp_valid,    1);
        check("wr_err_t7",    rsp_err,      0);
        check("wr_ctrl_t7",   bus.Mem_Ctrl, 4'b0000);
        check("wr_rdata_t7",  rsp_rdata,    8'hA5);
        tick();

        // ---------------- back-to-back: read then write in rsp cycle ----------------
        bus.acq = 1'b1;
        issue(1'b0, 8'h55, 8'h00);       // T+1, granted
        tick();                          // T+2 RDATA, acq still high (ignored)
        bus.Dq = 8'h5A;
        tick();                          // T+3 response
        bus.acq = 1'b0;
        check("b2b_rvalid", rsp_valid, 1);
        check("b2b_rdata",  rsp_rdata, 8'h5A);
        check("b2b_ready",  req_ready, 1);
        issue(1'b1, 8'h66, 8'h77);
        check("b2b_wr_ctrl", bus.Mem_Ctrl, 4'b0010);
        check("b2b_wr_addr", bus.Address,  8'h66);
        check("b2b_wr_din",  bus.Din,      8'h77);
        check("b2b_wr_rv",   rsp_valid,    0);
        bus.acq = 1'b1;
        tick();
        bus.acq = 1'b0;
        check("b2b_wr_rvalid", rsp_valid, 1);
        check("b2b_wr_rdata",  rsp_rdata, 8'h5A);
        tick();

        // ---------------- reset in second REQ cycle of a read ----------------
        issue(1'b0, 8'h20, 8'h00);       // T+1 REQ
        tick();                          // T+2 REQ (second)
        check("rstmid_ctrl_pre", bus.Mem_Ctrl, 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_ctrl", bus.Mem_Ctrl, 4'b0000);
        check("rstmid_busy", busy,         0);
        check("rstmid_rv",   rsp_valid,    0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstmid_norsp%0d", i), rsp_valid, 0);
        end
        bus.acq = 1'b1;
        issue(1'b0, 8'h34, 8'h00);
        check("post_rst_ctrl", bus.Mem_Ctrl, 4'b0001);
        check("post_rst_addr", bus.Address,  8'h34);
        tick();
        bus.acq = 1'b0;
        bus.Dq  = 8'hC3;
        tick();
        check("post_rst_rv",    rsp_valid, 1);
        check("post_rst_rdata", rsp_rdata, 8'hC3);
        tick();

`ifdef MEMPORT_TIMEOUT_EN
        // ---------------- timeout on a read ----------------
        bus.Dq = 8'h11;
        issue(1'b0, 8'h01, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_ctrl_c%0d", i), bus.Mem_Ctrl, 4'b0001);
            check($sformatf("to_rv_c%0d",   i), rsp_valid,    0);
            tick();
        end
        check("to_ctrl",   bus.Mem_Ctrl, 4'b0000);
        check("to_rvalid", rsp_valid,    1);
        check("to_err",    rsp_err,      1);
        check("to_rdata",  rsp_rdata,    8'hFF);
        check("to_busy",   busy,         0);
        tick();
        check("to_err_clr", rsp_err, 0);

        // ---------------- grant on the expiry cycle wins ----------------
        issue(1'b0, 8'h02, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("tw_ctrl_c%0d", i), bus.Mem_Ctrl, 4'b0001);
            bus.acq = (i == 4);
            tick();
        end
        bus.acq = 1'b0;
        bus.Dq  = 8'h99;
        check("tw_rv_rdata_cyc", rsp_valid,    0);
        check("tw_ctrl_rdata",   bus.Mem_Ctrl, 4'b0000);
        tick();
        check("tw_rvalid", rsp_valid, 1);
        check("tw_err",    rsp_err,   0);
        check("tw_rdata",  rsp_rdata, 8'h99);
        tick();
`else
        // ---------------- no timeout: REQ waits indefinitely ----------------
        issue(1'b1, 8'h03, 8'h44);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("hold_ctrl%0d", i), bus.Mem_Ctrl, 4'b0010);
            check($sformatf("hold_rv%0d",   i), rsp_valid,    0);
            tick();
        end
        bus.acq = 1'b1;
        tick();
        bus.acq = 1'b0;
        check("hold_rvalid", rsp_valid, 1);
        check("hold_err",    rsp_err,   0);
        check("hold_rdata",  rsp_rdata, 8'hC3);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
